fsa_header_tracker: RTL
=======================

Name: fsa_header_tracker

Overview:
- Parametrised fiber-header detector for the fusion-splice analysis pipeline.
- Per frame it captures reference fiber thickness from the first/last column of a reference row. On a scan row it finds the first run of win_len consecutive in-tolerance columns left of lft_edge and right of rt_edge.
- Results are published once per frame with a done pulse.
- Adds over the previous generation: runtime tolerance and run length, saturating bounds, invalid-column rejection, and optional hold-last-result mode with a stale flag.

Parameters:
- C_IMG_HW, 12, column/height coordinate width
- C_IMG_WW, 12, x coordinate width
- C_WIN_MAX, 15, maximum run length supported; run counter width is clog2(C_WIN_MAX+1)
- C_HOLD, 1, 1 = keep previous frame's result when no header is found; 0 = clear it

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- frame_start  in  1  clears per-frame working state
- tol  in  C_IMG_HW  height tolerance (+/-)
- win_len  in  clog2(C_WIN_MAX+1)  required run length
- col_en  in  1  column strobe; the column fields below are valid this cycle
- ref_row  in  1  current row is the reference row
- scan_row  in  1  current row is the scan row
- col_first  in  1  first column of row
- col_last  in  1  last column of row
- col_x  in  C_IMG_WW  column index
- col_top  in  C_IMG_HW  fiber top row in this column
- col_bot  in  C_IMG_HW  fiber bottom row in this column
- lft_edge  in  C_IMG_WW  left search limit, inclusive
- rt_edge  in  C_IMG_WW  right search start, inclusive
- lft_valid  out  1  published left header present
- lft_x  out  C_IMG_WW  left header start x
- lft_stale  out  1  lft_x is held from an earlier frame
- rt_valid  out  1  published right header present
- rt_x  out  C_IMG_WW  right header start x
- rt_stale  out  1  rt_x is held from an earlier frame
- scan_done  out  1  one-cycle publish pulse

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. All registers and outputs are 0.
- Stage 0 (edge after col_en): register h = col_bot - col_top (mod 2^C_IMG_HW), inv = (col_bot < col_top), col_x, and all row/col flags.
- Stage 1 reference capture:
  - ref_row & col_first & !inv: lref <= h, lref_ok <= 1.
  - ref_row & col_last & !inv: rref <= h, rref_ok <= 1.
  - If inv, the reference is not captured and its _ok flag stays 0.
  - A newly captured reference is used from the next column onward.
- Bounds: lower = ref - tol, saturating at 0; upper = ref + tol, saturating at all-ones. in_tol = ref_ok & !inv & lower <= h <= upper.
- Effective run length: wl = win_len, with 0 treated as 1 and values > C_WIN_MAX clamped to C_WIN_MAX.
- Left search, stage 1, scan_row, active while !lft_found and col_x <= lft_edge:
  - run <= in_tol ? min(run+1, C_WIN_MAX) : 0.
  - When in_tol and run+1 == wl: lft_found <= 1, lft_wx <= col_x - wl + 1.
- Right search: identical logic, active only for col_x >= rt_edge. Its counter is held at 0 before rt_edge. First run wins.
- Publish: on the stage-1 column carrying scan_row & col_last, scan_done pulses on the following edge and the outputs update on that same edge.
  - Found: valid = 1, x = working x, stale = 0.
  - Not found, C_HOLD = 1: x and valid keep their previous values; stale = valid.
  - Not found, C_HOLD = 0: valid = 0, x = 0, stale = 0.
- Latency: column at cycle t -> run evaluated at t+1 -> working result at t+2. Published outputs change only on the scan_done edge.
- Scan rows per frame: only the first scan row per frame is processed. Later scan rows are ignored until frame_start, so scan_done fires at most once per frame.
- frame_start: clears ref_ok, run counters, found flags, the scan-processed flag and the stage-0 register. Published outputs are untouched. frame_start has priority over any same-cycle column, which is dropped.
- A scan row with no captured reference yields "not found".
- ref_row and scan_row may coincide; the capture rule above applies.
- Reset mid-row abandons all state; no scan_done is produced.

Test Plan:
- Setup for all cases unless stated: win_len = 7, tol = 2, lft_edge = 100. Reference row gives h = 20 at the first column and h = 30 at the last.
- Left header: scan h = 20 at x = 10..16 -> scan_done pulse; lft_valid = 1, lft_x = 10, lft_stale = 0. Outputs unchanged before the pulse.
- Broken run: h = 20 at x = 10..14, h = 25 at x = 15, h = 21 at x = 16..22 -> lft_x = 16. Same case with bot < top at x = 15 -> also 16.
- Right header: rt_edge = 200, h = 29 at x = 190..210 -> rt_x = 200 (count starts at the edge). h = 33 everywhere -> no right header.
- Saturation: ref = 1, tol = 5, h = 0 for x = 10..16 -> lower bound saturates at 0; lft_x = 10. Repeat with win_len = 0 -> run length 1, lft_x = 10.
- Hold: C_HOLD = 1, frame 1 finds lft_x = 10; frame 2 has no run -> lft_valid = 1, lft_x = 10, lft_stale = 1. With C_HOLD = 0 -> lft_valid = 0, lft_x = 0.
- Abort: frame_start mid scan row -> no scan_done that frame. A second scan row in the same frame is ignored. resetn low mid-row -> all outputs 0.

Source files
------------

// File: rtl/fsa_header_tracker.sv
// Fiber-header detector: captures per-frame reference thickness, then finds the first
// in-tolerance run left of lft_edge and right of rt_edge on one scan row per frame.
module fsa_header_tracker #(
  parameter int C_IMG_HW  = 12,
  parameter int C_IMG_WW  = 12,
  parameter int C_WIN_MAX = 15,
  parameter int C_HOLD    = 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             frame_start,
  input  logic [C_IMG_HW-1:0]              tol,
  input  logic [$clog2(C_WIN_MAX+1)-1:0]   win_len,
  input  logic                             col_en,
  input  logic                             ref_row,
  input  logic                             scan_row,
  input  logic                             col_first,
  input  logic                             col_last,
  input  logic [C_IMG_WW-1:0]              col_x,
  input  logic [C_IMG_HW-1:0]              col_top,
  input  logic [C_IMG_HW-1:0]              col_bot,
  input  logic [C_IMG_WW-1:0]              lft_edge,
  input  logic [C_IMG_WW-1:0]              rt_edge,
  output logic                             lft_valid,
  output logic [C_IMG_WW-1:0]              lft_x,
  output logic                             lft_stale,
  output logic                             rt_valid,
  output logic [C_IMG_WW-1:0]              rt_x,
  output logic                             rt_stale,
  output logic                             scan_done
);

  localparam int WLW = $clog2(C_WIN_MAX + 1);
  localparam logic [WLW-1:0] WMAX = WLW'(C_WIN_MAX);

  logic                s0_v, s0_inv, s0_ref, s0_scan, s0_first, s0_last;
  logic [C_IMG_HW-1:0] s0_h;
  logic [C_IMG_WW-1:0] s0_x;

  logic [C_IMG_HW-1:0] lref, rref;
  logic                lref_ok, rref_ok;
  logic [WLW-1:0]      lrun, rrun;
  logic                lft_found, rt_found;
  logic [C_IMG_WW-1:0] lft_wx, rt_wx;
  logic                scan_seen, scan_act, pub_pend;

  logic [WLW-1:0]      wl, l_sat, r_sat;
  logic [WLW:0]        l_inc, r_inc;
  logic                l_tol, r_tol, proc, l_act, r_act;
  logic [C_IMG_WW-1:0] wx;

  function automatic logic in_tol_f(input logic [C_IMG_HW-1:0] rv,
                                    input logic [C_IMG_HW-1:0] h,
                                    input logic [C_IMG_HW-1:0] t,
                                    input logic ok, input logic inv);
    logic [C_IMG_HW:0]   up;
    logic [C_IMG_HW-1:0] lo, hi;
    lo = (rv > t) ? rv - t : '0;
    up = {1'b0, rv} + {1'b0, t};
    hi = up[C_IMG_HW] ? '1 : up[C_IMG_HW-1:0];
    return ok & ~inv & (h >= lo) & (h <= hi);
  endfunction

  always_comb begin
    wl = win_len;
    if (win_len == '0)
      wl = WLW'(1);
    else if (win_len > WMAX)
      wl = WMAX;
    l_inc = {1'b0, lrun} + (WLW+1)'(1);
    r_inc = {1'b0, rrun} + (WLW+1)'(1);
    l_sat = (l_inc > {1'b0, WMAX}) ? WMAX : l_inc[WLW-1:0];
    r_sat = (r_inc > {1'b0, WMAX}) ? WMAX : r_inc[WLW-1:0];
    l_tol = in_tol_f(lref, s0_h, tol, lref_ok, s0_inv);
    r_tol = in_tol_f(rref, s0_h, tol, rref_ok, s0_inv);
    wx    = s0_x - C_IMG_WW'(wl) + C_IMG_WW'(1);
    // A scan row counts only if its first column arrived in this frame and no
    // scan row has completed yet; this also drops rows cut by frame_start/reset.
    proc  = s0_v & s0_scan & ~scan_seen & (scan_act | s0_first);
    l_act = proc & ~lft_found & (s0_x <= lft_edge);
    r_act = proc & ~rt_found & (s0_x >= rt_edge);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s0_v <= 1'b0; s0_inv <= 1'b0; s0_ref <= 1'b0; s0_scan <= 1'b0;
      s0_first <= 1'b0; s0_last <= 1'b0; s0_h <= '0; s0_x <= '0;
      lref <= '0; rref <= '0; lref_ok <= 1'b0; rref_ok <= 1'b0;
      lrun <= '0; rrun <= '0; lft_found <= 1'b0; rt_found <= 1'b0;
      lft_wx <= '0; rt_wx <= '0;
      scan_seen <= 1'b0; scan_act <= 1'b0; pub_pend <= 1'b0;
      lft_valid <= 1'b0; lft_x <= '0; lft_stale <= 1'b0;
      rt_valid <= 1'b0; rt_x <= '0; rt_stale <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (frame_start) begin
        s0_v <= 1'b0; s0_inv <= 1'b0; s0_ref <= 1'b0; s0_scan <= 1'b0;
        s0_first <= 1'b0; s0_last <= 1'b0; s0_h <= '0; s0_x <= '0;
        lref_ok <= 1'b0; rref_ok <= 1'b0;
        lrun <= '0; rrun <= '0; lft_found <= 1'b0; rt_found <= 1'b0;
        scan_seen <= 1'b0; scan_act <= 1'b0; pub_pend <= 1'b0;
      end else begin
        s0_v <= col_en;
        if (col_en) begin
          s0_h     <= col_bot - col_top;
          s0_inv   <= (col_bot < col_top);
          s0_x     <= col_x;
          s0_ref   <= ref_row;
          s0_scan  <= scan_row;
          s0_first <= col_first;
          s0_last  <= col_last;
        end

        if (s0_v && s0_ref && s0_first && !s0_inv) begin
          lref <= s0_h; lref_ok <= 1'b1;
        end
        if (s0_v && s0_ref && s0_last && !s0_inv) begin
          rref <= s0_h; rref_ok <= 1'b1;
        end

        if (l_act) begin
          lrun <= l_tol ? l_sat : '0;
          if (l_tol && (l_inc == {1'b0, wl})) begin
            lft_found <= 1'b1; lft_wx <= wx;
          end
        end
        if (r_act) begin
          rrun <= r_tol ? r_sat : '0;
          if (r_tol && (r_inc == {1'b0, wl})) begin
            rt_found <= 1'b1; rt_wx <= wx;
          end
        end else if (proc && (s0_x < rt_edge)) begin
          rrun <= '0;
        end

        if (pub_pend) begin
          pub_pend  <= 1'b0;
          scan_done <= 1'b1;
          if (lft_found) begin
            lft_valid <= 1'b1; lft_x <= lft_wx; lft_stale <= 1'b0;
          end else if (C_HOLD != 0) begin
            lft_stale <= lft_valid;
          end else begin
            lft_valid <= 1'b0; lft_x <= '0; lft_stale <= 1'b0;
          end
          if (rt_found) begin
            rt_valid <= 1'b1; rt_x <= rt_wx; rt_stale <= 1'b0;
          end else if (C_HOLD != 0) begin
            rt_stale <= rt_valid;
          end else begin
            rt_valid <= 1'b0; rt_x <= '0; rt_stale <= 1'b0;
          end
        end

        if (proc) begin
          scan_act <= ~s0_last;
          if (s0_last) begin
            scan_seen <= 1'b1;
            pub_pend  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
